// File: rtl/block_renderer.sv
// rtl/block_renderer.sv - block field pixel renderer with row-store sequencing
// Walks a NUM_COLS x NUM_ROWS block field and gates pixels from the current row bitmap.
module block_renderer #(
  parameter int X_OFFSET = 24,
  parameter int Y_OFFSET = 40,
  parameter int BLOCK_W  = 45,
  parameter int BLOCK_H  = 10,
  parameter int NUM_COLS = 13,
  parameter int NUM_ROWS = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        frame_start,
  input  logic [12:0] line,
  output logic        next_line,
  output logic        pixel_on,
  output logic [3:0]  row_idx,
  output logic [3:0]  col_idx
);
  localparam int SW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int HW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [9:0]    X_BEG     = 10'(X_OFFSET);
  localparam logic [9:0]    X_END     = 10'(X_OFFSET + NUM_COLS * BLOCK_W);
  localparam logic [9:0]    Y_BEG     = 10'(Y_OFFSET);
  localparam logic [9:0]    Y_END     = 10'(Y_OFFSET + NUM_ROWS * BLOCK_H);
  localparam logic [SW-1:0] SUB_LAST  = SW'(BLOCK_W - 1);
  localparam logic [HW-1:0] YSUB_LAST = HW'(BLOCK_H - 1);
  localparam logic [3:0]    COL_LAST  = 4'(NUM_COLS - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESYNC = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d, sub_cur;
  logic [3:0]    col_q, col_d, col_cur;
  logic [HW-1:0] ysub_q, ysub_d, ysub_cur;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_idx_q, col_idx_d;
  logic          pixel_on_q, pixel_on_d;
  logic          in_x, in_y, next_line_c;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      sub_q      <= '0;
      col_q      <= '0;
      ysub_q     <= '0;
      row_q      <= '0;
      col_idx_q  <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      col_q      <= col_d;
      ysub_q     <= ysub_d;
      row_q      <= row_d;
      col_idx_q  <= col_idx_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ysub_d      = ysub_q;
    row_d       = row_q;
    pixel_on_d  = 1'b0;
    col_idx_d   = '0;
    next_line_c = 1'b0;

    in_x = (pix_x >= X_BEG) && (pix_x < X_END);
    in_y = (pix_y >= Y_BEG) && (pix_y < Y_END);

    // Counters restart at the field edge so the current pixel sees a zeroed value.
    sub_cur  = (pix_x == X_BEG) ? '0 : sub_q;
    col_cur  = (pix_x == X_BEG) ? '0 : col_q;
    ysub_cur = (pix_y == Y_BEG) ? '0 : ysub_q;

    if (sub_cur == SUB_LAST) begin
      sub_d = '0;
      col_d = (col_cur == COL_LAST) ? '0 : col_cur + 4'd1;
    end else begin
      sub_d = sub_cur + SW'(1);
      col_d = col_cur;
    end

    if (pix_x == X_END)
      ysub_d = (ysub_cur == YSUB_LAST) ? '0 : ysub_cur + HW'(1);

    case (state_q)
      IDLE: begin
        if (pix_y == Y_BEG) state_d = ACTIVE;
      end
      ACTIVE: begin
        pixel_on_d  = in_x && in_y && line[COL_LAST - col_cur] &&
                      (sub_cur != SUB_LAST) && (ysub_cur != YSUB_LAST);
        next_line_c = in_y && (pix_x == X_END) && (ysub_cur == YSUB_LAST);
        if (pix_y == Y_END) state_d = IDLE;
      end
      RESYNC: begin
        next_line_c = 1'b1;
        if (row_q == ROW_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new frame with the row store out of step flushes it back to row 0.
    if ((state_q != RESYNC) && frame_start && (row_q != '0))
      state_d = RESYNC;

    if (next_line_c)
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 4'd1;

    if (pixel_on_d)
      col_idx_d = col_cur;
  end

  assign next_line = next_line_c;
  assign pixel_on  = pixel_on_q;
  assign row_idx   = row_q;
  assign col_idx   = col_idx_q;
endmodule

// File: tb/tb_block_renderer.sv
// tb/tb_block_renderer.sv - scoreboard bench for block_renderer
// Reduced vertical geometry keeps full frames short; horizontal geometry is the default.
module tb_block_renderer;
  localparam int XO = 24;
  localparam int YO = 4;
  localparam int BW = 45;
  localparam int BH = 3;
  localparam int NC = 13;
  localparam int NR = 16;
  localparam int XE = XO + NC * BW;
  localparam int YE = YO + NR * BH;

  typedef struct {int cyc; int pix; int col;} pix_e;
  typedef struct {int cyc; int nl; int row;} nl_e;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        frame_start = 1'b0;
  logic [12:0] line;
  logic        next_line, pixel_on;
  logic [3:0]  row_idx, col_idx;

  logic [12:0] rows [NR];
  logic [3:0]  store_ptr;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nl_count = 0;
  int m_row = 0;
  int m_resync = 0;
  bit m_active = 0;
  pix_e pix_q[$];
  nl_e  nl_q[$];
  pix_e pe;
  nl_e  ne;

  block_renderer #(
    .X_OFFSET(XO), .Y_OFFSET(YO), .BLOCK_W(BW), .BLOCK_H(BH),
    .NUM_COLS(NC), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .nRst(nRst), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line(line), .next_line(next_line),
    .pixel_on(pixel_on), .row_idx(row_idx), .col_idx(col_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Row store shares reset and advances on every next_line pulse.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) store_ptr <= '0;
    else if (next_line) store_ptr <= store_ptr + 4'd1;
  end
  assign line = rows[store_ptr];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d (x=%0d y=%0d)",
               name, act, exp, cyc, pix_x, pix_y);
    end
  endtask

  // Reference: block position from division/modulo of the coordinates.
  task automatic model_step();
    int col, sub, ysub, pix, nl;
    bit in_x, in_y;
    in_x = (int'(pix_x) >= XO) && (int'(pix_x) < XE);
    in_y = (int'(pix_y) >= YO) && (int'(pix_y) < YE);
    col  = (int'(pix_x) - XO) / BW;
    sub  = (int'(pix_x) - XO) % BW;
    ysub = (int'(pix_y) - YO) % BH;
    pix  = 0;
    nl   = 0;
    if (m_resync > 0) nl = 1;
    else if (m_active && in_y) begin
      if (in_x && rows[m_row][NC-1-col] && sub != BW-1 && ysub != BH-1) pix = 1;
      if (int'(pix_x) == XE && ysub == BH-1) nl = 1;
    end
    pix_q.push_back('{cyc, pix, (pix != 0) ? col : 0});
    nl_q.push_back('{cyc, nl, m_row});
    if (m_resync > 0) begin
      m_resync--;
      m_row = (m_row + 1) % NR;
    end else if (frame_start && m_row != 0) begin
      m_resync = NR - m_row;
      m_active = 0;
    end else begin
      if (nl != 0) m_row = (m_row + 1) % NR;
      if (int'(pix_y) == YO) m_active = 1;
      if (int'(pix_y) == YE) m_active = 0;
    end
  endtask

  task automatic run_line(input int y, input int x0, input int x1, input int fs_a,
                          input int fs_b, input int rst_at, input int rel_at);
    for (int x = x0; x < x1; x++) begin
      @(posedge clk);
      #1;
      if (x == rel_at) nRst = 1'b1;
      pix_x = 10'(x);
      pix_y = 10'(y);
      frame_start = (x == fs_a) || (x == fs_b);
      if (x == rst_at) begin
        nRst = 1'b0;
        pix_q.delete();
        nl_q.delete();
        m_row = 0;
        m_active = 0;
        m_resync = 0;
        #1;
        check("rst_pixel_on", int'(pixel_on), 0);
        check("rst_next_line", int'(next_line), 0);
        check("rst_row_idx", int'(row_idx), 0);
        check("rst_col_idx", int'(col_idx), 0);
      end
      if (nRst) model_step();
    end
  endtask

  task automatic run_lines(input int y_first, input int y_last);
    for (int y = y_first; y <= y_last; y++) begin
      if ((y >= YO && y < YE) || y == YE || y == YE + 3)
        run_line(y, 20, 613, -1, -1, -1, -1);
      else if (y == 0)
        run_line(y, 0, 4, 0, -1, -1, -1);
      else
        run_line(y, 0, 4, -1, -1, -1, -1);
    end
  endtask

  always @(negedge clk) begin
    if (nRst) begin
      if (nl_q.size() > 0 && nl_q[0].cyc == cyc) begin
        ne = nl_q.pop_front();
        check("next_line", int'(next_line), ne.nl);
        check("row_idx", int'(row_idx), ne.row);
      end
      if (pix_q.size() > 0 && pix_q[0].cyc == cyc - 1) begin
        pe = pix_q.pop_front();
        check("pixel_on", int'(pixel_on), pe.pix);
        check("col_idx", int'(col_idx), pe.col);
      end
      if (next_line) nl_count++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) rows[i] = 13'($urandom);
    rows[0] = 13'h1000;
    rows[1] = 13'h1555;
    rows[2] = 13'h1FFF;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pixel_on", int'(pixel_on), 0);
    check("reset_next_line", int'(next_line), 0);
    check("reset_row_idx", int'(row_idx), 0);
    check("reset_col_idx", int'(col_idx), 0);
    nRst = 1'b1;

    nl_count = 0;
    run_lines(0, YE + 7);
    check("frame1_pulses", nl_count, NR);
    check("frame1_row_end", int'(row_idx), 0);

    for (int i = 3; i < NR; i++) rows[i] = 13'($urandom);
    run_lines(0, 24);
    check("frame2_row_before_reset", int'(row_idx), 7);
    run_line(25, 20, 613, -1, -1, 300, 310);
    run_lines(26, 27);

    run_lines(0, 19);
    check("frame3_row_before_resync", int'(row_idx), 5);

    nl_count = 0;
    run_line(0, 0, 20, 0, 3, -1, -1);
    check("resync_pulses", nl_count, NR - 5);
    check("resync_row_end", int'(row_idx), 0);
    nl_count = 0;
    run_lines(1, YE + 7);
    check("frame4_pulses", nl_count, NR);
    check("frame4_row_end", int'(row_idx), 0);

    run_line(YE + 8, 0, 4, -1, -1, -1, -1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/block_renderer.md
BLOCK_RENDERER -- requirements
Module: block_renderer

Interface
REQ-001 Parameters SHALL be: X_OFFSET, default 24, first field pixel column; Y_OFFSET, default 40, first field scanline; BLOCK_W, default 45, block pitch in pixels; BLOCK_H, default 10, block pitch in scanlines; NUM_COLS, default 13, blocks per row; NUM_ROWS, default 16, rows held by the upstream row store.
REQ-002 Ports SHALL be:
  clk        in   1   clock
  nRst       in   1   reset, asynchronous, active-low
  pix_x      in   10  current pixel column; increments by 1 per clk within a scanline
  pix_y      in   10  current scanline
  frame_start in  1   one-cycle pulse at pix_x=0, pix_y=0
  line       in   13  current row bitmap from the row store; bit 12 is the leftmost block
  next_line  out  1   one-cycle pulse that advances the row store by one row
  pixel_on   out  1   block pixel visible, registered
  row_idx    out  4   row currently presented on line
  col_idx    out  4   block column of the registered pixel_on

Function
REQ-003 Field SHALL be X_OFFSET <= pix_x < X_END and Y_OFFSET <= pix_y < Y_END, where X_END = X_OFFSET+NUM_COLS*BLOCK_W (609) and Y_END = Y_OFFSET+NUM_ROWS*BLOCK_H (200).
REQ-004 FSM SHALL have states IDLE (outside the field rows), ACTIVE (pix_y inside the field) and RESYNC.
REQ-005 Transitions SHALL be: IDLE->ACTIVE when pix_y=Y_OFFSET; ACTIVE->IDLE when pix_y=Y_END; any state->RESYNC on frame_start with row_idx!=0; RESYNC->IDLE after its last pulse; frame_start with row_idx=0 SHALL cause no transition.
REQ-006 Column tracking SHALL use counters, not division: sub-pixel counter 0..BLOCK_W-1 and col counter 0..NUM_COLS-1, both zeroed at pix_x=X_OFFSET; col increments when sub wraps.
REQ-007 Scanline sub-counter 0..BLOCK_H-1 SHALL be zeroed at pix_y=Y_OFFSET and advance once per scanline.
REQ-008 Pixel_on SHALL have 1-cycle latency: pixel_on(t+1) = ACTIVE and in field and line[12-col] and sub!=BLOCK_W-1 and scanline-sub!=BLOCK_H-1; last column and last scanline of each block are a 1-pixel gap.
REQ-009 col_idx SHALL be registered alongside pixel_on; it is 0 when pixel_on=0.
REQ-010 In ACTIVE, next_line SHALL pulse for one cycle at pix_x=X_END on every scanline where scanline-sub=BLOCK_H-1, giving exactly NUM_ROWS pulses per complete frame.
REQ-011 row_idx SHALL increment on every next_line pulse and wrap from NUM_ROWS-1 to 0.
REQ-012 RESYNC SHALL pulse next_line on NUM_ROWS-row_idx consecutive cycles, ending with row_idx=0.
REQ-013 pixel_on SHALL be 0 throughout RESYNC.
REQ-014 frame_start during RESYNC SHALL be ignored.
REQ-015 line SHALL be sampled combinationally and is valid at every cycle except the cycle immediately after a next_line pulse.
REQ-016 pix_x beyond X_END or pix_y beyond Y_END SHALL never produce pixel_on or extra next_line pulses.

Reset
REQ-017 When nRst=0, outputs SHALL immediately become pixel_on=0, next_line=0, row_idx=0, col_idx=0; all counters SHALL clear and the FSM SHALL enter IDLE.
REQ-018 Reset deassertion mid-frame SHALL output nothing until pix_y reaches Y_OFFSET or frame_start arrives.
REQ-019 The row store SHALL share nRst so that both start aligned at row 0.

Verification
REQ-020 Reset: nRst=0 during an active scanline -> pixel_on=0, next_line=0, row_idx=0 in the same cycle.
REQ-021 line=13'h1000, pix_y=40, pix_x sweep 0..639 -> pixel_on=1 in the cycles following pix_x=24..67 (44 pixels), 0 everywhere else, col_idx=0.
REQ-022 line=13'h1FFF, pix_y=49 (gap scanline) -> pixel_on=0 for the whole line; single next_line pulse at pix_x=609; row_idx 0->1.
REQ-023 Full 640x480 frame after reset -> exactly 16 next_line pulses (pix_y=49,59,...,199 at pix_x=609); row_idx ends at 0.
REQ-024 Reset deasserted at pix_y=100 (row_idx=0), frame_start at row_idx=5 -> 11 consecutive next_line pulses, pixel_on=0 throughout, then row_idx=0 and FSM IDLE.
REQ-025 line=13'b1010101010101, pix_y=41 -> 7 runs of 44 pixel_on cycles, starting after pix_x=24,114,...,564; col_idx=0,2,...,12.
